// File: rtl/synapse_scan_ctrl_pkg.sv
// Shared types and helpers for the per-tick synaptic connection sweep.
// Holds the sequencer state encoding and the axon index width helper.
package synapse_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

    // Occupancy width of the two-entry hit buffer (0..2).
    localparam int FIFO_CNT_W = 2;

    function automatic int axon_w(input int num_axons);
        return $clog2(num_axons);
    endfunction

endpackage

// File: rtl/scan_out_fifo.sv
// Two-entry first-word-fall-through buffer for hit axon indices.
// The head is visible whenever count is non-zero; push and pop may share a cycle.
module scan_out_fifo
    import synapse_scan_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          push_data,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [W-1:0]          head_data,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [1:0][W-1:0]     mem_q, mem_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/synapse_scan_ctrl.sv
// Per-tick sequencer: sweeps every axon through the 1-cycle connection memory,
// gates each returned bit with the tick's spike snapshot and streams hits out.
module synapse_scan_ctrl
    import synapse_scan_ctrl_pkg::*;
#(
    parameter int NUM_AXONS   = 256,
    parameter int CON_LATENCY = 1,
    parameter int FIFO_DEPTH  = 2,
    localparam int AXON_W     = axon_w(NUM_AXONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [NUM_AXONS-1:0] axon_spikes,
    output logic [AXON_W-1:0]    axon_number,
    output logic                 rd_en,
    input  logic                 con_in,
    output logic                 integ_valid,
    output logic [AXON_W-1:0]    integ_axon,
    input  logic                 integ_ready,
    output logic                 busy,
    output logic                 done,
    output logic [AXON_W:0]      hit_count,
    output logic                 overrun
);

    if (CON_LATENCY != 1) begin : g_bad_latency
        $error("synapse_scan_ctrl: only CON_LATENCY = 1 is supported");
    end
    if (FIFO_DEPTH != 2) begin : g_bad_depth
        $error("synapse_scan_ctrl: FIFO_DEPTH is fixed at 2");
    end
    if (NUM_AXONS < 4 || (NUM_AXONS & (NUM_AXONS - 1)) != 0) begin : g_bad_axons
        $error("synapse_scan_ctrl: NUM_AXONS must be a power of two >= 4");
    end

    scan_state_t           state_q, state_d;
    logic [AXON_W-1:0]     axon_number_q, axon_number_d;
    logic [AXON_W-1:0]     addr_q, addr_d;
    logic                  inflight_q, inflight_d;
    logic [NUM_AXONS-1:0]  spike_q, spike_d;
    logic [AXON_W:0]       hit_count_q, hit_count_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;

    logic                  pop, hit, issue, drain_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [2:0]            credit_used;

    // integ_valid/integ_axon describe the FIFO head; a transfer happens in any
    // cycle where integ_valid && integ_ready, and the head is held until then.
    always_comb begin
        pop         = integ_valid & integ_ready;
        hit         = inflight_q & con_in & spike_q[addr_q];
        credit_used = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight_q};
        issue       = (state_q == SCAN) && (credit_used < 3'(FIFO_DEPTH));
        drain_empty = ({1'b0, fifo_count} + {2'b00, hit} - {2'b00, pop}) == 3'd0;

        state_d       = state_q;
        axon_number_d = axon_number_q;
        addr_d        = addr_q;
        inflight_d    = issue;
        spike_d       = spike_q;
        hit_count_d   = hit_count_q;
        done_d        = 1'b0;
        overrun_d     = 1'b0;

        if (hit) begin
            hit_count_d = hit_count_q + 1'b1;
        end
        if (issue) begin
            addr_d        = axon_number_q;
            axon_number_d = axon_number_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    spike_d       = axon_spikes;
                    hit_count_d   = '0;
                    axon_number_d = '0;
                    state_d       = SCAN;
                end
            end
            SCAN: begin
                overrun_d = tick;
                // The increment above wraps axon_number back to 0 on the last issue.
                if (issue && axon_number_q == AXON_W'(NUM_AXONS - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                overrun_d = tick;
                // Exit once nothing is in flight and the buffer empties this cycle.
                if (drain_empty) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            axon_number_q <= '0;
            addr_q        <= '0;
            inflight_q    <= 1'b0;
            spike_q       <= '0;
            hit_count_q   <= '0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            axon_number_q <= axon_number_d;
            addr_q        <= addr_d;
            inflight_q    <= inflight_d;
            spike_q       <= spike_d;
            hit_count_q   <= hit_count_d;
            done_q        <= done_d;
            overrun_q     <= overrun_d;
        end
    end

    scan_out_fifo #(.W(AXON_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (hit),
        .push_data  (addr_q),
        .pop        (pop),
        .head_valid (integ_valid),
        .head_data  (integ_axon),
        .count      (fifo_count)
    );

    assign axon_number = axon_number_q;
    assign rd_en       = issue;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign hit_count   = hit_count_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/synapse_scan_ctrl.md
Name: synapse_scan_ctrl

Overview:
Per-tick sequencer for one neuron's synaptic connection memory: the 256x1 bit, LUT6-based, 1-cycle registered read array indexed by axon number.
- On each tick it snapshots the axon spike vector and sweeps axon_number 0..NUM_AXONS-1 through the connection memory.
- It ANDs each returned connection bit with the snapshot spike bit.
- Each hit is delivered to the neuron integrator over a valid/ready interface.
- Sits between the core's tick/spike buffer and the neuron block; end of sweep is reported with a done pulse and a hit count.

Parameters:
NUM_AXONS, 256, number of axons swept per tick; power of two, >=4.
CON_LATENCY, 1, connection memory read latency in cycles; only 1 is supported and is asserted by elaboration check.
FIFO_DEPTH, 2, output buffer entries; fixed.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
tick  in  1  start-of-sweep strobe; single-cycle.
axon_spikes  in  NUM_AXONS  spike vector, sampled only on an accepted tick.
axon_number  out  $clog2(NUM_AXONS)  connection memory read address.
rd_en  out  1  high in cycles where axon_number is a real issue.
con_in  in  1  connection bit; valid the cycle after the issuing cycle.
integ_valid  out  1  hit available.
integ_axon  out  $clog2(NUM_AXONS)  axon index of the hit.
integ_ready  in  1  integrator accepts.
busy  out  1  sweep in progress (state != IDLE).
done  out  1  one-cycle pulse at end of sweep.
hit_count  out  $clog2(NUM_AXONS)+1  hits in the last sweep; stable from done until the next accepted tick.
overrun  out  1  one-cycle pulse when tick arrives while busy.

Behaviour:
- Reset values:
  - state=IDLE.
  - axon_number=0, rd_en=0.
  - integ_valid=0, integ_axon=0.
  - busy=0, done=0, overrun=0, hit_count=0.
  - FIFO empty, in-flight flag clear.
- States: IDLE, SCAN, DRAIN.
- IDLE + tick:
  - Latch axon_spikes into spike_reg; clear hit_count.
  - Go to SCAN with axon_number=0, rd_en=1 in the next cycle.
- Tick while busy: ignored; overrun=1 the next cycle; sweep unaffected.
- SCAN issue rule:
  - Issue (rd_en=1) only when fifo_count - pop + inflight < FIFO_DEPTH, where pop = integ_valid & integ_ready this cycle.
  - When the rule blocks issue: rd_en=0 and axon_number holds.
  - Each issue sets inflight for the next cycle and increments axon_number.
- Return path:
  - In the cycle after an issue, hit = con_in & spike_reg[addr_d], where addr_d is the registered issued address.
  - A hit is pushed into the FIFO (integ_axon=addr_d) and increments hit_count; a miss is dropped.
  - con_in is ignored when inflight=0.
- Output:
  - integ_valid/integ_axon come from the FIFO head.
  - The head holds stable until handshake.
  - Push and pop in the same cycle are allowed.
  - Hits leave in ascending axon order.
- Last issue (address NUM_AXONS-1):
  - Go to DRAIN; axon_number wraps to 0, rd_en=0.
  - No further issues.
- DRAIN exit: when inflight=0 and FIFO empty (accounting for a same-cycle pop), done=1 the next cycle and state goes to IDLE.
- Throughput: with integ_ready held high, one axon per cycle, no bubbles.
- Latency, with the tick cycle as cycle 0:
  - axon 0 is issued in cycle 1.
  - The first possible integ_valid is in cycle 3.
  - All hits with ready high: done in cycle NUM_AXONS+3.
  - Zero hits: done in cycle NUM_AXONS+2.
- Reset mid-sweep: immediate return to reset values; no done pulse; FIFO contents discarded.
- hit_count saturation is unnecessary; the width holds NUM_AXONS.

Decomposition:
- Shared package: scan_state_t enum {IDLE, SCAN, DRAIN} and AXON_W = $clog2(NUM_AXONS) helper.
- One sub-module: scan_out_fifo. It is a 2-entry synchronous FIFO of AXON_W bits with push/pop/count, first-word-fall-through head.
- Issue credit logic, counters and FSM stay in the top.

Test Plan:
- All connections=1, all spikes=1, ready high, tick at cycle 0:
  - integ_axon 0..255 on cycles 3..258, no gaps.
  - done at cycle 259; hit_count=256.
- Connection pattern 64'hba502b6aaaac7467 in the low 64 bits (rest 0), spikes all 1:
  - outputs are exactly the set-bit indices, ascending.
  - hit_count equals the popcount (32).
- Spikes all 0: no integ_valid; done at cycle 258; hit_count=0; rd_en covers cycles 1..256.
- All hits, integ_ready toggling 1-of-3 cycles:
  - no loss or duplication; integ_axon stable while valid && !ready.
  - rd_en never issues beyond FIFO credit.
  - FIFO count never exceeds 2.
- Tick asserted at cycle 50 mid-sweep: overrun pulse at cycle 51; sweep results identical to the unperturbed run.
- rst at cycle 100 mid-sweep, then a new tick: no done from the aborted sweep; all outputs at reset values; the new sweep starts at axon 0 and is correct.
